rvseed_cpu: RTL and testbench
=============================

// Module: rvseed_cpu
// PURPOSE
//   Single-cycle RV32I-subset processor core; the top of the rvseed design, with no external buses.
//   Contains the PC, decoder, register file, ALU, an instruction ROM (u_inst_mem_0) and a data RAM.
//   Programs are preloaded by the bench with $readmemh into u_inst_mem_0.inst_mem_f.
//   One instruction retires per clock after reset is released.
// PARAMETERS
//   IMEM_DEPTH  256  instruction-memory depth, in 32-bit words
//   DMEM_DEPTH  256  data-memory depth, in 32-bit words
//   RESET_PC    0    PC value while reset is asserted and after reset is released
// PORTS
//   clk    in  1  single core clock; all state updates on the rising edge
//   rst_n  in  1  asynchronous, active-low reset
// BEHAVIOUR
//   Hierarchy (fixed for bench access):
//   - Instruction ROM: u_inst_mem_0.inst_mem_f [0:IMEM_DEPTH-1], 32-bit words.
//   - Register file: u_regs_0.regs [0:31], 32-bit.
//   Reset (async, rst_n=0): PC=RESET_PC; regs[1..31]=0. Memory contents are not cleared.
//   Fetch: inst = inst_mem_f[PC[31:2] mod IMEM_DEPTH]; combinational. PC[1:0] is ignored.
//   Execution: decode, ALU, branch resolution and writeback all complete in the same cycle.
//   - One instruction retires per clk edge while rst_n=1.
//   - The next PC is PC+4 unless a taken branch or jump redirects it.
//   Supported instructions:
//   - R-type: ADD SUB AND OR XOR SLT SLTU SLL SRL SRA.
//   - I-type: ADDI ANDI ORI XORI SLTI SLLI SRLI SRAI.
//   - LUI, LW, SW, BEQ, BNE, JAL, JALR.
//   Arithmetic: 32-bit two's complement, wrap-around, no overflow traps.
//   - Shift amount is rs2[4:0] (R-type) or imm[4:0] (I-type).
//   - SLT is signed; SLTU is unsigned.
//   x0: reads always return 0; writes to x0 are discarded.
//   Register-file read ports are combinational. If rd==rs, the old value is read; the new value lands at the edge.
//   Data RAM:
//   - Word addressed by (rs1+imm)[31:2] mod DMEM_DEPTH; low address bits are ignored.
//   - Load data is combinational. SW writes at the clock edge.
//   Branches:
//   - target = PC + sign-extended B-immediate.
//   - A BEQ/BNE whose condition is false falls through to PC+4.
//   Jumps:
//   - JAL: rd=PC+4; PC=PC+J-immediate.
//   - JALR: rd=PC+4; PC=(rs1+imm)&~1.
//   Illegal or unsupported opcode (including all-zero and X words): executes as a NOP, PC+4, no state change.
//   Reset asserted mid-program: PC immediately returns to RESET_PC; any in-flight write is dropped; execution restarts on release.
// CONFIGURATION
//   RVSEED_TRACE_EN defined:
//   - After each retired instruction, the core prints via $display: "PC=%h INST=%h RD=x%0d WDATA=%h".
//   - RD and WDATA are printed only when a register write occurs.
//   RVSEED_TRACE_EN undefined:
//   - No trace output.
//   - Functionally identical; synthesizable logic is unaffected.
// TESTING
//   1. ADD program [addi x1,x0,5; addi x2,x0,7; add x3,x1,x2] -> x1=5, x2=7, x3=12 after 3 edges; PC=0x0C.
//   2. Reset hold: rst_n=0 for 1 cycle -> PC=0, regs=0; first fetch on release is inst_mem_f[0].
//   3. SUB/SLT: x1=3, x2=-1 -> SUB gives x3=4; SLT x4,x2,x1 gives 1; SLTU x5,x2,x1 gives 0.
//   4. Memory: addi x1,x0,0x55; sw x1,8(x0); lw x2,8(x0) -> x2=0x55.
//   5. Branch/jump: taken BEQ skips the next instruction; JAL writes rd=PC+4.
//      - Also: a write to x0 leaves x0=0.
//   6. Mid-run reset: assert rst_n after 4 instructions -> PC=0 and regs cleared at once.
//      - After release, the program re-executes with the same results as test 1.

Source files
------------

// File: rtl/rvseed_cpu.sv
// rvseed_cpu -- single-cycle RV32I-subset core, top of the rvseed design.
//
// Every instruction is fetched, decoded, executed and written back in one
// clock. The core owns its instruction ROM (u_inst_mem_0), register file
// (u_regs_0) and a word-addressed data RAM; it has no external buses.
//
// Ports:
//   clk    core clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset; PC -> RESET_PC, x1..x31 -> 0
//
// Parameters:
//   IMEM_DEPTH  instruction ROM depth in 32-bit words (power of two)
//   DMEM_DEPTH  data RAM depth in 32-bit words (power of two)
//   RESET_PC    PC value held during reset and used on release
//
// Optional feature (macro RVSEED_TRACE_EN): when defined, each retired
// instruction prints "PC=%h INST=%h RD=x%0d WDATA=%h" (RD/WDATA only when a
// register is written). Undefined, no trace logic exists at all.

// Instruction ROM. Contents are loaded from outside (bench preload); the core
// only reads it combinationally.
//   addr  word index into the ROM
//   data  instruction word at that index
module rvseed_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] inst_mem_f [0:DEPTH-1];

  assign data = inst_mem_f[addr];
endmodule

// 32 x 32 register file, two combinational read ports, one write port.
// x0 reads as zero and ignores writes. A read of the register being written
// returns the old value; the new one appears after the edge.
module rvseed_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];
endmodule

module rvseed_cpu #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic clk,
  input  logic rst_n
);
  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

  function automatic logic [31:0] alu_calc(input alu_op_e op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {31'b0, (a < b)};
      ALU_SLTU: r = {31'b0, ($unsigned(a) < $unsigned(b))};
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = $unsigned(a) >> b[4:0];
      ALU_SRA:  r = a >>> b[4:0];
      default:  r = a + b;
    endcase
    return r;
  endfunction

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] inst;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_op;

  logic        reg_we;
  logic        mem_we;
  logic        use_imm;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;

  logic signed [31:0] rs1_val;
  logic signed [31:0] rs2_val;
  logic signed [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] wb_data;
  logic [31:0] load_data;
  logic        branch_taken;
  logic [DA_W-1:0] d_idx;

  logic [31:0] dmem [0:DMEM_DEPTH-1];

  // Fetch: low PC bits are ignored, upper bits wrap modulo the ROM depth.
  rvseed_imem #(.DEPTH(IMEM_DEPTH)) u_inst_mem_0 (
    .addr (pc[IA_W+1:2]),
    .data (inst)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};

  // Decode. Anything not explicitly recognised leaves every enable low,
  // which makes it a NOP that simply advances the PC.
  always_comb begin
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    imm_op    = imm_i;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    case (opcode)
      OPC_OP: begin
        reg_we = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: alu_op = ALU_ADD;
          {7'h20, 3'd0}: alu_op = ALU_SUB;
          {7'h00, 3'd1}: alu_op = ALU_SLL;
          {7'h00, 3'd2}: alu_op = ALU_SLT;
          {7'h00, 3'd3}: alu_op = ALU_SLTU;
          {7'h00, 3'd4}: alu_op = ALU_XOR;
          {7'h00, 3'd5}: alu_op = ALU_SRL;
          {7'h20, 3'd5}: alu_op = ALU_SRA;
          {7'h00, 3'd6}: alu_op = ALU_OR;
          {7'h00, 3'd7}: alu_op = ALU_AND;
          default:       reg_we = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        reg_we  = 1'b1;
        use_imm = 1'b1;
        case (f3)
          3'd0: alu_op = ALU_ADD;
          3'd2: alu_op = ALU_SLT;
          3'd4: alu_op = ALU_XOR;
          3'd6: alu_op = ALU_OR;
          3'd7: alu_op = ALU_AND;
          3'd1: begin
            if (f7 == 7'h00) alu_op = ALU_SLL;
            else             reg_we = 1'b0;
          end
          3'd5: begin
            if (f7 == 7'h00)      alu_op = ALU_SRL;
            else if (f7 == 7'h20) alu_op = ALU_SRA;
            else                  reg_we = 1'b0;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OPC_LUI: begin
        reg_we = 1'b1;
        wb_sel = WB_IMM;
      end
      OPC_LOAD: begin
        if (f3 == 3'd2) begin
          reg_we  = 1'b1;
          use_imm = 1'b1;
          wb_sel  = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'd2) begin
          mem_we  = 1'b1;
          use_imm = 1'b1;
          imm_op  = imm_s;
        end
      end
      OPC_BRANCH: begin
        if (f3 == 3'd0 || f3 == 3'd1) is_branch = 1'b1;
      end
      OPC_JAL: begin
        reg_we = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == 3'd0) begin
          reg_we  = 1'b1;
          use_imm = 1'b1;
          wb_sel  = WB_PC4;
          is_jalr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  rvseed_regfile u_regs_0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (reg_we),
    .waddr   (rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rs1_val),
    .rdata_b (rs2_val)
  );

  // The ALU also forms load/store addresses and the JALR target.
  assign alu_b   = use_imm ? imm_op : rs2_val;
  assign alu_res = alu_calc(alu_op, rs1_val, alu_b);

  assign d_idx     = alu_res[DA_W+1:2];
  assign load_data = dmem[d_idx];

  // Stores are suppressed while reset is held so an in-flight SW is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) dmem[d_idx] <= rs2_val;
  end

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_ALU: wb_data = alu_res;
      WB_MEM: wb_data = load_data;
      WB_PC4: wb_data = pc_plus4;
      WB_IMM: wb_data = imm_u;
      default: wb_data = alu_res;
    endcase
  end

  assign pc_plus4     = pc + 32'd4;
  assign branch_taken = is_branch && (f3[0] ? (rs1_val != rs2_val) : (rs1_val == rs2_val));

  always_comb begin
    pc_next = pc_plus4;
    if (is_jal)            pc_next = pc + imm_j;
    else if (is_jalr)      pc_next = {alu_res[31:1], 1'b0};
    else if (branch_taken) pc_next = pc + imm_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

`ifdef RVSEED_TRACE_EN
  // Values are sampled before this edge's updates land, i.e. the retiring
  // instruction's own PC and result.
  always @(posedge clk) begin
    if (rst_n) begin
      if (reg_we && (rd != 5'd0))
        $display("PC=%h INST=%h RD=x%0d WDATA=%h", pc, inst, rd, wb_data);
      else
        $display("PC=%h INST=%h", pc, inst);
    end
  end
`endif
endmodule

// File: tb/tb_rvseed_cpu.sv
// tb_rvseed_cpu -- directed self-checking bench for rvseed_cpu.
// Programs are written straight into the instruction ROM through hierarchy;
// architectural state is observed through the PC and register file.
module tb_rvseed_cpu;
  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  rvseed_cpu dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rg(input logic [4:0] n);
    return dut.u_regs_0.regs[n];
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    dut.u_inst_mem_0.inst_mem_f[idx] = w;
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 256; k++) put(k, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_add_prog();
    clear_imem();
    put(0, addi(5'd1, 5'd0, 12'd5));
    put(1, addi(5'd2, 5'd0, 12'd7));
    put(2, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
  endtask

  initial begin
    rst_n = 1'b0;

    // ADD program
    load_add_prog();
    do_reset();
    check("rst_pc", dut.pc, 32'h0);
    check("rst_x1", rg(5'd1), 32'h0);
    step(3);
    check("add_x1", rg(5'd1), 32'd5);
    check("add_x2", rg(5'd2), 32'd7);
    check("add_x3", rg(5'd3), 32'd12);
    check("add_pc", dut.pc, 32'h0000000c);

    // Reset hold for one cycle, then first fetch from word 0
    rst_n = 1'b0;
    #1;
    check("hold_pc_async", dut.pc, 32'h0);
    @(posedge clk);
    #1;
    check("hold_pc", dut.pc, 32'h0);
    check("hold_x1", rg(5'd1), 32'h0);
    check("hold_x3", rg(5'd3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("rel_x1", rg(5'd1), 32'd5);
    check("rel_x2", rg(5'd2), 32'd0);
    check("rel_pc", dut.pc, 32'h4);

    // ALU coverage
    clear_imem();
    put(0,  addi(5'd1, 5'd0, 12'd3));
    put(1,  addi(5'd2, 5'd0, 12'hfff));
    put(2,  enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
    put(3,  enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4));
    put(4,  enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5));
    put(5,  enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd6));
    put(6,  enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd7));
    put(7,  enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd8));
    put(8,  enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd9));
    put(9,  enc_r(7'h00, 5'd1, 5'd2, 3'd5, 5'd10));
    put(10, enc_r(7'h20, 5'd1, 5'd2, 3'd5, 5'd11));
    put(11, {20'h12345, 5'd13, 7'b0110111});
    put(12, enc_i(12'h004, 5'd1, 3'd1, 5'd14, 7'b0010011));
    put(13, enc_i(12'h000, 5'd2, 3'd2, 5'd15, 7'b0010011));
    put(14, enc_i(12'hfff, 5'd1, 3'd4, 5'd16, 7'b0010011));
    put(15, enc_i(12'h010, 5'd1, 3'd6, 5'd17, 7'b0010011));
    put(16, enc_i(12'h0f0, 5'd2, 3'd7, 5'd18, 7'b0010011));
    put(17, enc_i(12'h01c, 5'd2, 3'd5, 5'd19, 7'b0010011));
    put(18, enc_i(12'h404, 5'd13, 3'd5, 5'd20, 7'b0010011));
    put(19, enc_r(7'h00, 5'd1, 5'd7, 3'd0, 5'd21));
    put(20, enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd22));
    put(21, enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd23));
    do_reset();
    step(22);
    check("sub", rg(5'd3), 32'd4);
    check("slt_neg", rg(5'd4), 32'd1);
    check("sltu_big", rg(5'd5), 32'd0);
    check("and", rg(5'd6), 32'h3);
    check("or", rg(5'd7), 32'hffffffff);
    check("xor", rg(5'd8), 32'hfffffffc);
    check("sll", rg(5'd9), 32'h18);
    check("srl", rg(5'd10), 32'h1fffffff);
    check("sra", rg(5'd11), 32'hffffffff);
    check("lui", rg(5'd13), 32'h12345000);
    check("slli", rg(5'd14), 32'h30);
    check("slti", rg(5'd15), 32'd1);
    check("xori", rg(5'd16), 32'hfffffffc);
    check("ori", rg(5'd17), 32'h13);
    check("andi", rg(5'd18), 32'hf0);
    check("srli", rg(5'd19), 32'hf);
    check("srai", rg(5'd20), 32'h01234500);
    check("add_wrap", rg(5'd21), 32'd2);
    check("sltu_small", rg(5'd22), 32'd1);
    check("slt_pos", rg(5'd23), 32'd0);
    check("alu_pc", dut.pc, 32'h58);

    // Data memory
    clear_imem();
    put(0, addi(5'd1, 5'd0, 12'h055));
    put(1, enc_s(12'd8, 5'd1, 5'd0));
    put(2, enc_i(12'd8, 5'd0, 3'd2, 5'd2, 7'b0000011));
    put(3, addi(5'd3, 5'd0, 12'h100));
    put(4, enc_s(12'd4, 5'd3, 5'd3));
    put(5, enc_i(12'h107, 5'd0, 3'd2, 5'd4, 7'b0000011));
    put(6, enc_i(12'h408, 5'd0, 3'd2, 5'd5, 7'b0000011));
    put(7, enc_i(12'd8, 5'd0, 3'd2, 5'd0, 7'b0000011));
    do_reset();
    step(8);
    check("lw", rg(5'd2), 32'h55);
    check("lw_lowbits", rg(5'd4), 32'h100);
    check("lw_wrap", rg(5'd5), 32'h55);
    check("lw_x0", rg(5'd0), 32'h0);
    check("mem_pc", dut.pc, 32'h20);

    // Branches, jumps, x0 writes, illegal opcode
    clear_imem();
    put(0,  addi(5'd1, 5'd0, 12'd1));
    put(1,  addi(5'd2, 5'd0, 12'd1));
    put(2,  enc_b(13'd8, 5'd2, 5'd1, 3'd0));
    put(3,  addi(5'd3, 5'd0, 12'd99));
    put(4,  enc_b(13'd8, 5'd2, 5'd1, 3'd1));
    put(5,  addi(5'd4, 5'd0, 12'd4));
    put(6,  enc_j(21'd8, 5'd5));
    put(7,  addi(5'd6, 5'd0, 12'd66));
    put(8,  addi(5'd0, 5'd0, 12'd123));
    put(9,  enc_i(12'd21, 5'd5, 3'd0, 5'd7, 7'b1100111));
    put(10, addi(5'd8, 5'd0, 12'd8));
    put(11, addi(5'd8, 5'd0, 12'd8));
    put(12, addi(5'd9, 5'd0, 12'd9));
    put(13, 32'hffffffff);
    do_reset();
    step(10);
    check("beq_skip", rg(5'd3), 32'd0);
    check("bne_fall", rg(5'd4), 32'd4);
    check("jal_link", rg(5'd5), 32'h1c);
    check("jal_skip", rg(5'd6), 32'd0);
    check("x0_write", rg(5'd0), 32'd0);
    check("jalr_link", rg(5'd7), 32'h28);
    check("jalr_skip", rg(5'd8), 32'd0);
    check("jalr_tgt", rg(5'd9), 32'd9);
    check("illegal_pc", dut.pc, 32'h38);

    // Mid-run reset
    load_add_prog();
    put(3, addi(5'd4, 5'd1, 12'd1));
    do_reset();
    step(4);
    check("mid_x4", rg(5'd4), 32'd6);
    rst_n = 1'b0;
    #1;
    check("mid_pc", dut.pc, 32'h0);
    check("mid_x1", rg(5'd1), 32'h0);
    check("mid_x3", rg(5'd3), 32'h0);
    check("mid_x4_clr", rg(5'd4), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("rerun_x1", rg(5'd1), 32'd5);
    check("rerun_x2", rg(5'd2), 32'd7);
    check("rerun_x3", rg(5'd3), 32'd12);
    check("rerun_x4", rg(5'd4), 32'd0);
    check("rerun_pc", dut.pc, 32'h0000000c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
